// File: rtl/systolic_skew_feeder_if.sv
// Bundle between the skew feeder, its local matrix memory and the 5-lane
// downstream FIFO: start/status handshake, memory read port, lane outputs.
interface systolic_skew_feeder_if #(
  parameter int DW = 32,
  parameter int AW = 8
);
  // Start / status handshake
  logic          init;
  logic [AW-1:0] base_address;
  logic          busy;
  logic          com;

  // Single-port local memory read port (data returns one cycle after rd_en)
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;

  // Downstream FIFO lane inputs and back-pressure
  logic          hold;
  logic [DW-1:0] out0;
  logic [DW-1:0] out1;
  logic [DW-1:0] out2;
  logic [DW-1:0] out3;
  logic [DW-1:0] out4;
  logic [4:0]    wr_en;

  // The feeder itself
  modport master (
    input  init, base_address, hold, rd_data,
    output busy, com, rd_en, rd_addr, out0, out1, out2, out3, out4, wr_en
  );

  // The environment: controller, memory and FIFO
  modport slave (
    output init, base_address, hold, rd_data,
    input  busy, com, rd_en, rd_addr, out0, out1, out2, out3, out4, wr_en
  );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Systolic skew feeder: loads a 5x5 matrix from local memory (row-major,
// address wraps modulo 2^AW), then streams it column-per-lane into the
// 5-lane FIFO with lane k lagging lane 0 by k steps. One-cycle com pulse
// once the stream is complete.
module systolic_skew_feeder #(
  parameter int DW = 32,
  parameter int AW = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  systolic_skew_feeder_if.master bus
);

  localparam int N  = 5;      // lanes / matrix dimension
  localparam int NE = N * N;  // matrix elements

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_CAP    = 3'd2,
    ST_STREAM = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Control state
  state_e        state_q;
  logic [4:0]    idx_q;    // element currently being read (row-major)
  logic [AW-1:0] base_q;   // latched base address
  logic [3:0]    step_q;   // next stream step to emit, 0..9 (9 = all emitted)

  // Registered outputs
  logic          rd_en_q;
  logic [AW-1:0] rd_addr_q;
  logic [DW-1:0] out_q [N];
  logic [N-1:0]  wr_en_q;
  logic          busy_q;
  logic          com_q;

  // Matrix buffer, flat row-major
  logic [DW-1:0] mat_q [NE];

  // Next lane values for the current step
  logic [DW-1:0] lane_data_d [N];
  logic [N-1:0]  lane_we_d;

  // Buffer write control
  logic          cap_en_s;
  logic [4:0]    cap_idx_s;

  // Lane k carries row (step - k) of column k while that row is in range.
  function automatic logic lane_active(input logic [3:0] step, input int lane);
    int row;
    row = int'(step) - lane;
    return (row >= 32'sd0) && (row < N);
  endfunction

  // Flat buffer index of the element lane k carries at a given step.
  function automatic logic [4:0] elem_index(input logic [3:0] step, input int lane);
    int row;
    row = int'(step) - lane;
    return 5'(row * N + lane);
  endfunction

  // Select the diagonal element each lane presents at the current step
  always_comb begin
    lane_data_d = '{default: '0};
    lane_we_d   = '0;
    for (int k = 0; k < N; k++) begin
      if (lane_active(step_q, k)) begin
        lane_data_d[k] = mat_q[elem_index(step_q, k)];
        lane_we_d[k]   = 1'b1;
      end else begin
        lane_data_d[k] = '0;
        lane_we_d[k]   = 1'b0;
      end
    end
  end

  // Read data returns one cycle after its strobe, so it belongs to the previous index
  always_comb begin
    cap_en_s  = 1'b0;
    cap_idx_s = 5'd0;
    case (state_q)
      ST_LOAD: begin
        cap_en_s  = (idx_q != 5'd0);
        cap_idx_s = idx_q - 5'd1;
      end
      ST_CAP: begin
        cap_en_s  = 1'b1;
        cap_idx_s = idx_q;
      end
      default: begin
        cap_en_s  = 1'b0;
        cap_idx_s = 5'd0;
      end
    endcase
  end

  // Matrix buffer capture; contents survive reset on purpose
  always_ff @(posedge clk_i) begin
    if (!rst_i && cap_en_s) begin
      mat_q[cap_idx_s] <= bus.rd_data;
    end
  end

  // Sequencer: load, capture, skewed stream, completion pulse
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      idx_q     <= 5'd0;
      base_q    <= '0;
      step_q    <= 4'd0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      out_q     <= '{default: '0};
      wr_en_q   <= '0;
      busy_q    <= 1'b0;
      com_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          com_q   <= 1'b0;
          wr_en_q <= '0;
          if (bus.init) begin
            state_q   <= ST_LOAD;
            base_q    <= bus.base_address;
            idx_q     <= 5'd0;
            step_q    <= 4'd0;
            rd_en_q   <= 1'b1;
            rd_addr_q <= bus.base_address;
            busy_q    <= 1'b1;
          end else begin
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end

        ST_LOAD: begin
          if (idx_q == 5'd24) begin
            state_q <= ST_CAP;
            rd_en_q <= 1'b0;
          end else begin
            idx_q     <= idx_q + 5'd1;
            rd_addr_q <= base_q + AW'(idx_q + 5'd1);
            rd_en_q   <= 1'b1;
          end
        end

        // Last read lands here; step 0 only needs M[0][0], already buffered,
        // so this edge is also the first stream step.
        ST_CAP: begin
          state_q <= ST_STREAM;
          if (bus.hold) begin
            wr_en_q <= '0;
          end else begin
            out_q   <= lane_data_d;
            wr_en_q <= lane_we_d;
            step_q  <= step_q + 4'd1;
          end
        end

        ST_STREAM: begin
          if (step_q == 4'd9) begin
            state_q <= ST_DONE;
            com_q   <= 1'b1;
            wr_en_q <= '0;
            out_q   <= '{default: '0};
          end else if (bus.hold) begin
            wr_en_q <= '0;
          end else begin
            out_q   <= lane_data_d;
            wr_en_q <= lane_we_d;
            step_q  <= step_q + 4'd1;
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
          com_q   <= 1'b0;
          busy_q  <= 1'b0;
          wr_en_q <= '0;
          out_q   <= '{default: '0};
        end

        default: begin
          state_q <= ST_IDLE;
          rd_en_q <= 1'b0;
          wr_en_q <= '0;
          busy_q  <= 1'b0;
          com_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rd_en   = rd_en_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.out0    = out_q[0];
  assign bus.out1    = out_q[1];
  assign bus.out2    = out_q[2];
  assign bus.out3    = out_q[3];
  assign bus.out4    = out_q[4];
  assign bus.wr_en   = wr_en_q;
  assign bus.busy    = busy_q;
  assign bus.com     = com_q;

endmodule
